// File: rtl/muldiv_sequencer_if.sv
// Decode-side bundle for the HI/LO multiply/divide sequencer.
// Decode drives the request fields and reads back HI/LO, stall and completion status.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             stall;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  hi, lo, stall, done, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, stall, done, div_by_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MULTU/DIVU sequencer with architectural HI/LO and MTHI/MTLO writes.
// MULTU/DIVU: WIDTH+2 cycles with stall high WIDTH+1 of them; MTHI/MTLO: 0 cycles, no stall.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   opa;      // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0]   opb;      // multiplier (shifted right), or divisor
  logic               is_div;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [5:0]         cnt;

  logic accept, mt_write, last;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;

  assign accept   = (state == IDLE) && bus.start && !bus.op[1];
  assign mt_write = (state == IDLE) && bus.start &&  bus.op[1];
  assign last     = (cnt == 6'(WIDTH - 1));

  // Shift-add: the product's low bits enter the accumulator from the top, so after
  // WIDTH steps acc holds the full product without ever shifting the multiplicand.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (opb[0] ? opa : {WIDTH{1'b0}})};
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};
  end

  // Restoring step; the kept remainder is always below the divisor, so WIDTH bits suffice.
  always_comb begin
    div_shift = {rem, opa[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb});
    div_diff  = div_shift[WIDTH-1:0] - opb;
    rem_nxt   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    quo_nxt   = {opa[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.stall       = accept || (state == RUN);
    bus.done        = (state == DONE);
    bus.div_by_zero = (state == DONE) && is_div && (opb == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opa    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      acc    <= '0;
      rem    <= '0;
      cnt    <= '0;
    end else begin
      if (mt_write) begin
        if (bus.op[0]) lo_q <= bus.a;
        else           hi_q <= bus.a;
      end
      if (accept) begin
        opa    <= bus.a;
        opb    <= bus.b;
        is_div <= bus.op[0];
        acc    <= '0;
        rem    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 6'd1;
        if (is_div) begin
          rem <= rem_nxt;
          opa <= quo_nxt;
          if (last) begin
            lo_q <= quo_nxt;
            hi_q <= rem_nxt;
          end
        end else begin
          acc <= mul_nxt;
          opb <= opb >> 1;
          if (last) {hi_q, lo_q} <= mul_nxt;
        end
      end
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboarded random and directed bench for muldiv_sequencer against an arithmetic model.
module tb_muldiv_sequencer;

  logic clk;
  logic rst_n;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_seen = 0;
  logic [31:0] model_hi = 0;
  logic [31:0] model_lo = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    if (o == 2'b00) begin
      p    = 64'(x) * 64'(y);
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.dbz = 1'b0;
    end else if (y == 0) begin
      e.hi = x;
      e.lo = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
    end else begin
      e.hi = x % y;
      e.lo = x / y;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_hi", bus.hi, e.hi);
        check("result_lo", bus.lo, e.lo);
        check("result_dbz", bus.div_by_zero, e.dbz);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int   stalls, done_at;
    e = model(o, x, y);
    exp_q.push_back(e);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    stalls    = 0;
    done_at   = -1;
    for (int c = 0; c < 60 && done_at < 0; c++) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      if (bus.done) done_at = c;
      tick();
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
    end
    check("done_latency", 64'(done_at), 64'd33);
    check("stall_cycles", 64'(stalls), 64'd33);
    @(negedge clk);
    check("dbz_one_cycle", bus.div_by_zero, 0);
    tick();
    model_hi = e.hi;
    model_lo = e.lo;
  endtask

  task automatic mt_op(input logic lo_sel, input logic [31:0] x);
    bus.start = 1'b1;
    bus.op    = {1'b1, lo_sel};
    bus.a     = x;
    @(negedge clk);
    check("mt_stall", bus.stall, 0);
    tick();
    bus.start = 1'b0;
    if (lo_sel) model_lo = x;
    else        model_hi = x;
  endtask

  task automatic check_arch(input string tag);
    @(negedge clk);
    check({tag, "_hi"}, bus.hi, model_hi);
    check({tag, "_lo"}, bus.lo, model_lo);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_done", bus.done, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul_max_hi", bus.hi, 32'hFFFF_FFFE);
    check("mul_max_lo", bus.lo, 32'h0000_0001);

    run_op(2'b01, 32'd100, 32'd7);
    check("div_100_7_lo", bus.lo, 32'd14);
    check("div_100_7_hi", bus.hi, 32'd2);

    run_op(2'b01, 32'h0000_1234, 32'd0);
    check("div0_lo", bus.lo, 32'hFFFF_FFFF);
    check("div0_hi", bus.hi, 32'h0000_1234);

    mt_op(1'b0, 32'hDEAD_BEEF);
    mt_op(1'b1, 32'h0BAD_F00D);
    @(negedge clk);
    check("mthi_val", bus.hi, 32'hDEAD_BEEF);
    check("mtlo_val", bus.lo, 32'h0BAD_F00D);
    tick();

    // Reset during RUN discards the operation.
    base      = done_seen;
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrun_rst_stall", bus.stall, 0);
    check("midrun_rst_hi", bus.hi, 0);
    check("midrun_rst_lo", bus.lo, 0);
    check("midrun_rst_done", bus.done, 0);
    tick();
    repeat (40) tick();
    check("midrun_no_done", 64'(done_seen - base), 64'd0);
    model_hi = 0;
    model_lo = 0;

    // start held through DONE; operands changed mid-run.
    base      = done_seen;
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    exp_q.push_back(model(2'b00, 32'd6, 32'd7));
    for (int c = 0; c <= 34; c++) begin
      if (c == 5) begin
        bus.a = 32'd9;
        bus.b = 32'd11;
      end
      if (c == 34) exp_q.push_back(model(2'b00, 32'd9, 32'd11));
      @(negedge clk);
      if (c == 33) begin
        check("hold_done_c33", bus.done, 1);
        check("hold_stall_c33", bus.stall, 0);
        check("hold_lo_c33", bus.lo, 32'd42);
      end
      if (c == 34) begin
        check("hold_reaccept_c34", bus.stall, 1);
        check("hold_single_done", 64'(done_seen - base), 64'd1);
      end
      tick();
    end
    bus.start = 1'b0;
    for (int c = 0; c < 40 && done_seen < base + 2; c++) tick();
    check("hold_second_done", 64'(done_seen - base), 64'd2);
    tick();
    model_hi = 32'd0;
    model_lo = 32'd99;
    check_arch("hold_arch");

    for (int i = 0; i < 14; i++) begin
      int          r;
      logic [31:0] x, y;
      r = $urandom_range(0, 9);
      x = $urandom;
      y = $urandom;
      if (r < 4) begin
        if ($urandom_range(0, 1) == 1) y = $urandom_range(0, 255);
        run_op(2'b00, x, y);
      end else if (r < 8) begin
        case ($urandom_range(0, 3))
          0:       y = 32'd0;
          1:       y = $urandom_range(1, 300);
          default: y = $urandom;
        endcase
        run_op(2'b01, x, y);
      end else begin
        mt_op(r[0], x);
      end
      check_arch("rand_arch");
      repeat ($urandom_range(0, 3)) tick();
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
